zmem_cache: RTL and testbench

- Parametrised successor to the Z80 memory manager's fixed 256x16 direct-mapped read cache.
- Sits between the page-resolved CPU access path and the DRAM arbiter port.
- Adds configurable depth and address width, explicit request/done handshakes, selectable write policy (invalidate or write-update), hardware flush walker (also run after reset), and hit/miss statistics.

---
 rtl/zmem_cache.sv | 221 ++++++++++++++++++++++
 tb/tb_zmem_cache.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/zmem_cache.sv
// zmem_cache: direct-mapped read cache between the page-resolved CPU access
// path and the DRAM arbiter port. 2^IDX_W lines of one 16-bit word each.
// Writes go through to DRAM. A write hit either invalidates the line
// (WRITE_MODE=0) or byte-merges the data into it (WRITE_MODE=1). The flush
// walker clears every valid bit, one index per cycle, after reset and on a
// flush pulse. hit_cnt and miss_cnt are saturating read statistics.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   cache_en                 caching allowed for the current access
//   flush                    one-cycle pulse: invalidate all lines
//   rd_req, wr_req           one-cycle request strobes (ignored while busy)
//   addr, wr_be, wdata       request address / byte enables / write data
//   rdata, rd_done           read data and its one-cycle completion pulse
//   wr_done                  one-cycle write completion pulse
//   busy, hit                not idle; registered result of the last lookup
//   dram_*                   DRAM arbiter request port
//   hit_cnt, miss_cnt        saturating read hit / miss counters
module zmem_cache #(
  parameter int unsigned ADDR_W     = 21,
  parameter int unsigned IDX_W      = 8,
  parameter bit          WRITE_MODE = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cache_en,
  input  logic              flush,
  input  logic              rd_req,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] addr,
  input  logic [1:0]        wr_be,
  input  logic [15:0]       wdata,
  output logic [15:0]       rdata,
  output logic              rd_done,
  output logic              wr_done,
  output logic              busy,
  output logic              hit,
  output logic              dram_req,
  output logic              dram_we,
  output logic [ADDR_W-1:0] dram_addr,
  output logic [1:0]        dram_be,
  output logic [15:0]       dram_wdata,
  input  logic [15:0]       dram_rddata,
  input  logic              dram_next,
  input  logic              dram_strobe,
  output logic [15:0]       hit_cnt,
  output logic [15:0]       miss_cnt
);

  localparam int unsigned TAG_W = ADDR_W - IDX_W;
  localparam int unsigned DEPTH = 1 << IDX_W;

  typedef enum logic [2:0] {
    S_FLUSH,
    S_IDLE,
    S_LOOKUP,
    S_MISS,
    S_FILL,
    S_WRITE
  } state_t;

  state_t state, next_state;

  // Tag entry layout: {valid, tag}
  logic [TAG_W:0]   tag_ram  [DEPTH];
  logic [15:0]      data_ram [DEPTH];
  logic [TAG_W:0]   tag_q;
  logic [15:0]      word_q;

  logic             tag_we, data_we;
  logic [IDX_W-1:0] ram_idx;
  logic [TAG_W:0]   tag_wdata;
  logic [15:0]      data_wdata;

  logic [IDX_W-1:0] flush_idx;
  logic             flush_pend;
  logic             op_wr;
  logic             rec_hit;
  logic [15:0]      rec_word;
  logic             lookup_hit;
  logic             accept;
  logic [15:0]      merged_word;

  // The arrays read the live request address, so the registered read result
  // lines up with the LOOKUP cycle that follows the accepted request.
  always_ff @(posedge clk) begin
    if (tag_we) tag_ram[ram_idx] <= tag_wdata;
    if (data_we) data_ram[ram_idx] <= data_wdata;
    tag_q  <= tag_ram[addr[IDX_W-1:0]];
    word_q <= data_ram[addr[IDX_W-1:0]];
  end

  assign lookup_hit = tag_q[TAG_W] && cache_en &&
                      (tag_q[TAG_W-1:0] == dram_addr[ADDR_W-1:IDX_W]);

  assign merged_word = {dram_be[1] ? dram_wdata[15:8] : rec_word[15:8],
                        dram_be[0] ? dram_wdata[7:0]  : rec_word[7:0]};

  // Requests are taken only in IDLE with no flush waiting.
  assign accept = (state == S_IDLE) && !flush && !flush_pend;

  assign busy     = (state != S_IDLE);
  assign dram_req = (state == S_MISS) || (state == S_WRITE);
  assign dram_we  = (state == S_WRITE);

  always_comb begin
    next_state = state;
    tag_we     = 1'b0;
    data_we    = 1'b0;
    ram_idx    = dram_addr[IDX_W-1:0];
    tag_wdata  = {1'b1, dram_addr[ADDR_W-1:IDX_W]};
    data_wdata = dram_rddata;
    case (state)
      S_FLUSH: begin
        tag_we    = 1'b1;
        ram_idx   = flush_idx;
        tag_wdata = '0;
        if (!flush && (flush_idx == '1)) next_state = S_IDLE;
      end
      S_IDLE: begin
        if (flush || flush_pend)  next_state = S_FLUSH;
        else if (rd_req || wr_req) next_state = S_LOOKUP;
      end
      S_LOOKUP: begin
        if (op_wr)           next_state = S_WRITE;
        else if (lookup_hit) next_state = S_IDLE;
        else                 next_state = S_MISS;
      end
      S_MISS: begin
        if (dram_next) next_state = S_FILL;
      end
      S_FILL: begin
        if (dram_strobe) begin
          next_state = S_IDLE;
          tag_we     = cache_en;
          data_we    = cache_en;
        end
      end
      S_WRITE: begin
        if (dram_next) begin
          next_state = S_IDLE;
          if (rec_hit) begin
            if (WRITE_MODE) begin
              data_we    = 1'b1;
              data_wdata = merged_word;
            end else begin
              tag_we    = 1'b1;
              tag_wdata = '0;
            end
          end
        end
      end
      default: next_state = S_FLUSH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_FLUSH;
      flush_idx  <= '0;
      flush_pend <= 1'b0;
      op_wr      <= 1'b0;
      rec_hit    <= 1'b0;
      rec_word   <= '0;
      dram_addr  <= '0;
      dram_be    <= '0;
      dram_wdata <= '0;
      rdata      <= '0;
      rd_done    <= 1'b0;
      wr_done    <= 1'b0;
      hit        <= 1'b0;
      hit_cnt    <= '0;
      miss_cnt   <= '0;
    end else begin
      state   <= next_state;
      rd_done <= 1'b0;
      wr_done <= 1'b0;

      // A flush pulse inside the walk restarts it at index 0.
      if (state == S_FLUSH) flush_idx <= flush ? '0 : flush_idx + IDX_W'(1);
      else                  flush_idx <= '0;

      if (state == S_IDLE)                    flush_pend <= 1'b0;
      else if (state != S_FLUSH && flush)     flush_pend <= 1'b1;

      if (accept) begin
        if (rd_req) begin
          dram_addr <= addr;
          op_wr     <= 1'b0;
        end else if (wr_req) begin
          dram_addr  <= addr;
          dram_be    <= wr_be;
          dram_wdata <= wdata;
          op_wr      <= 1'b1;
        end
      end

      if (state == S_LOOKUP) begin
        hit <= lookup_hit;
        if (op_wr) begin
          rec_hit  <= lookup_hit;
          rec_word <= word_q;
        end else if (lookup_hit) begin
          rdata   <= word_q;
          rd_done <= 1'b1;
          if (hit_cnt != '1) hit_cnt <= hit_cnt + 16'd1;
        end else begin
          if (miss_cnt != '1) miss_cnt <= miss_cnt + 16'd1;
        end
      end

      if (state == S_FILL && dram_strobe) begin
        rdata   <= dram_rddata;
        rd_done <= 1'b1;
      end

      if (state == S_WRITE && dram_next) wr_done <= 1'b1;
    end
  end

endmodule

// File: tb/tb_zmem_cache.sv
// Directed bench for zmem_cache. m0 is built with WRITE_MODE=0 and m1 with
// WRITE_MODE=1. Both share every input, and the DRAM responder reacts to m0.
module tb_zmem_cache;

  logic        clk = 1'b0;
  logic        rst, cache_en, flush, rd_req, wr_req;
  logic [20:0] addr;
  logic [1:0]  wr_be;
  logic [15:0] wdata, dram_rddata;
  logic        dram_next, dram_strobe;

  logic [15:0] m0_rdata, m1_rdata, m0_dram_wdata, m1_dram_wdata;
  logic        m0_rd_done, m1_rd_done, m0_wr_done, m1_wr_done;
  logic        m0_busy, m1_busy, m0_hit, m1_hit;
  logic        m0_dram_req, m1_dram_req, m0_dram_we, m1_dram_we;
  logic [20:0] m0_dram_addr, m1_dram_addr;
  logic [1:0]  m0_dram_be, m1_dram_be;
  logic [15:0] m0_hit_cnt, m1_hit_cnt, m0_miss_cnt, m1_miss_cnt;

  int n_checks = 0;
  int n_err    = 0;

  always #5 clk = ~clk;

  zmem_cache #(.ADDR_W(21), .IDX_W(8), .WRITE_MODE(1'b0)) dut0 (
    .clk(clk), .rst(rst), .cache_en(cache_en), .flush(flush),
    .rd_req(rd_req), .wr_req(wr_req), .addr(addr), .wr_be(wr_be),
    .wdata(wdata), .rdata(m0_rdata), .rd_done(m0_rd_done),
    .wr_done(m0_wr_done), .busy(m0_busy), .hit(m0_hit),
    .dram_req(m0_dram_req), .dram_we(m0_dram_we), .dram_addr(m0_dram_addr),
    .dram_be(m0_dram_be), .dram_wdata(m0_dram_wdata),
    .dram_rddata(dram_rddata), .dram_next(dram_next),
    .dram_strobe(dram_strobe), .hit_cnt(m0_hit_cnt), .miss_cnt(m0_miss_cnt)
  );

  zmem_cache #(.ADDR_W(21), .IDX_W(8), .WRITE_MODE(1'b1)) dut1 (
    .clk(clk), .rst(rst), .cache_en(cache_en), .flush(flush),
    .rd_req(rd_req), .wr_req(wr_req), .addr(addr), .wr_be(wr_be),
    .wdata(wdata), .rdata(m1_rdata), .rd_done(m1_rd_done),
    .wr_done(m1_wr_done), .busy(m1_busy), .hit(m1_hit),
    .dram_req(m1_dram_req), .dram_we(m1_dram_we), .dram_addr(m1_dram_addr),
    .dram_be(m1_dram_be), .dram_wdata(m1_dram_wdata),
    .dram_rddata(dram_rddata), .dram_next(dram_next),
    .dram_strobe(dram_strobe), .hit_cnt(m1_hit_cnt), .miss_cnt(m1_miss_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Results of the last do_read / do_write
  int          r_lat, r1_lat, w_lat, bcnt;
  logic        r_saw, r_req_after, w_we0, w_we1, w_done1, stray;
  logic [15:0] r_data, r1_data, w_wdata;
  logic [20:0] w_addr;
  logic [1:0]  w_be;

  // Issue one read; answer m0's DRAM request with next, then strobe d one
  // cycle later. fl=1 pulses flush during the FILL wait.
  task automatic do_read(input logic [20:0] a, input logic [15:0] d, input logic fl);
    int phase;
    phase = 0; r_saw = 1'b0; r_req_after = 1'b0; r1_lat = 0; r1_data = '0;
    @(negedge clk); addr = a; rd_req = 1'b1;
    @(negedge clk); rd_req = 1'b0; r_lat = 1;
    while (!m0_rd_done && r_lat < 40) begin
      if (m1_rd_done && r1_lat == 0) begin r1_lat = r_lat; r1_data = m1_rdata; end
      if (m0_dram_req) r_saw = 1'b1;
      dram_next = 1'b0; dram_strobe = 1'b0; flush = 1'b0;
      case (phase)
        0: if (m0_dram_req && !m0_dram_we) begin dram_next = 1'b1; phase = 1; end
        1: begin r_req_after = m0_dram_req; if (fl) flush = 1'b1; phase = 2; end
        2: begin dram_strobe = 1'b1; dram_rddata = d; phase = 3; end
        default: ;
      endcase
      @(negedge clk); r_lat++;
    end
    if (m1_rd_done && r1_lat == 0) begin r1_lat = r_lat; r1_data = m1_rdata; end
    dram_next = 1'b0; dram_strobe = 1'b0; flush = 1'b0;
    r_data = m0_rdata;
    chk("rd_done_seen", {31'd0, m0_rd_done}, 32'd1);
  endtask

  task automatic do_write(input logic [20:0] a, input logic [1:0] be, input logic [15:0] d);
    logic accepted;
    accepted = 1'b0; w_we0 = 1'b0; w_we1 = 1'b0; w_done1 = 1'b0;
    @(negedge clk); addr = a; wr_be = be; wdata = d; wr_req = 1'b1;
    @(negedge clk); wr_req = 1'b0; w_lat = 1;
    while (!m0_wr_done && w_lat < 40) begin
      dram_next = 1'b0;
      if (m1_dram_req && m1_dram_we) w_we1 = 1'b1;
      if (m0_dram_req && m0_dram_we && !accepted) begin
        w_we0 = 1'b1; w_addr = m0_dram_addr; w_be = m0_dram_be; w_wdata = m0_dram_wdata;
        dram_next = 1'b1; accepted = 1'b1;
      end
      @(negedge clk); w_lat++;
    end
    dram_next = 1'b0;
    w_done1 = m1_wr_done;
    chk("wr_done_seen", {31'd0, m0_wr_done}, 32'd1);
  endtask

  // Count consecutive busy cycles from the current negedge, watching for strays.
  task automatic count_busy();
    bcnt = 0; stray = 1'b0;
    while (m0_busy && bcnt < 400) begin
      if (m0_rd_done || m0_dram_req) stray = 1'b1;
      bcnt++;
      if (bcnt == 5) begin addr = 21'h01234; rd_req = 1'b1; end
      else rd_req = 1'b0;
      @(negedge clk);
    end
    rd_req = 1'b0;
  endtask

  initial begin
    rst = 1'b1; cache_en = 1'b1; flush = 1'b0; rd_req = 1'b0; wr_req = 1'b0;
    addr = '0; wr_be = '0; wdata = '0; dram_rddata = '0;
    dram_next = 1'b0; dram_strobe = 1'b0;

    // Reset and power-up flush walk
    repeat (2) @(negedge clk);
    chk("rst_busy", {31'd0, m0_busy}, 32'd1);
    chk("rst_rd_done", {31'd0, m0_rd_done}, 32'd0);
    chk("rst_dram_req", {31'd0, m0_dram_req}, 32'd0);
    chk("rst_hit", {31'd0, m0_hit}, 32'd0);
    chk("rst_rdata", {16'd0, m0_rdata}, 32'd0);
    rst = 1'b0;
    count_busy();
    chk("init_busy_cycles", bcnt, 32'd256);
    chk("init_no_response", {31'd0, stray}, 32'd0);
    repeat (3) @(negedge clk);
    chk("init_no_late_done", {31'd0, m0_rd_done}, 32'd0);
    chk("init_hit_cnt", {16'd0, m0_hit_cnt}, 32'd0);
    chk("init_miss_cnt", {16'd0, m0_miss_cnt}, 32'd0);

    // Miss then hit
    do_read(21'h01234, 16'hBEEF, 1'b0);
    chk("miss_dram_req", {31'd0, r_saw}, 32'd1);
    chk("miss_req_drop", {31'd0, r_req_after}, 32'd0);
    chk("miss_rdata", {16'd0, r_data}, 32'h0000BEEF);
    chk("miss_cnt_1", {16'd0, m0_miss_cnt}, 32'd1);
    chk("miss_hit_flag", {31'd0, m0_hit}, 32'd0);
    do_read(21'h01234, 16'h0BAD, 1'b0);
    chk("hit_latency", r_lat, 32'd2);
    chk("hit_no_dram", {31'd0, r_saw}, 32'd0);
    chk("hit_rdata", {16'd0, r_data}, 32'h0000BEEF);
    chk("hit_cnt_1", {16'd0, m0_hit_cnt}, 32'd1);
    chk("hit_flag", {31'd0, m0_hit}, 32'd1);

    // Conflict on index 0x34
    do_read(21'h01234, 16'h0BAD, 1'b0);
    chk("conf_hit", {31'd0, r_saw}, 32'd0);
    do_read(21'h00234, 16'h1111, 1'b0);
    chk("conf_miss_a", {31'd0, r_saw}, 32'd1);
    chk("conf_rdata_a", {16'd0, r_data}, 32'h00001111);
    do_read(21'h01234, 16'hBEEF, 1'b0);
    chk("conf_miss_b", {31'd0, r_saw}, 32'd1);
    chk("conf_miss_cnt", {16'd0, m0_miss_cnt}, 32'd3);

    // cache_en=0: DRAM read, no hit, no allocation
    cache_en = 1'b0;
    do_read(21'h01234, 16'h2222, 1'b0);
    chk("nc_dram", {31'd0, r_saw}, 32'd1);
    chk("nc_rdata", {16'd0, r_data}, 32'h00002222);
    chk("nc_hit_flag", {31'd0, m0_hit}, 32'd0);
    chk("nc_miss_cnt", {16'd0, m0_miss_cnt}, 32'd4);
    cache_en = 1'b1;
    do_read(21'h01234, 16'hDEAD, 1'b0);
    chk("nc_no_alloc_hit", {31'd0, r_saw}, 32'd0);
    chk("nc_no_alloc_data", {16'd0, r_data}, 32'h0000BEEF);
    chk("nc_hit_cnt", {16'd0, m0_hit_cnt}, 32'd3);

    // Flush pulse during FILL
    do_read(21'h00777, 16'h7777, 1'b1);
    chk("ff_rdata", {16'd0, r_data}, 32'h00007777);
    chk("ff_idle_gap", {31'd0, m0_busy}, 32'd0);
    @(negedge clk);
    count_busy();
    chk("ff_busy_cycles", bcnt, 32'd256);
    do_read(21'h00777, 16'h7778, 1'b0);
    chk("ff_refetch", {31'd0, r_saw}, 32'd1);
    chk("ff_miss_cnt", {16'd0, m0_miss_cnt}, 32'd6);

    // Hit counter saturation
    force dut0.hit_cnt = 16'hFFFE;
    #1 release dut0.hit_cnt;
    do_read(21'h00777, 16'h0BAD, 1'b0);
    chk("sat_data", {16'd0, r_data}, 32'h00007778);
    chk("sat_cnt_a", {16'd0, m0_hit_cnt}, 32'h0000FFFF);
    do_read(21'h00777, 16'h0BAD, 1'b0);
    chk("sat_cnt_b", {16'd0, m0_hit_cnt}, 32'h0000FFFF);

    // Reset asserted while in MISS
    @(negedge clk); addr = 21'h00999; rd_req = 1'b1;
    @(negedge clk); rd_req = 1'b0;
    @(negedge clk);
    chk("rstmiss_req", {31'd0, m0_dram_req}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    chk("rstmiss_req_drop", {31'd0, m0_dram_req}, 32'd0);
    chk("rstmiss_no_done", {31'd0, m0_rd_done}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    count_busy();
    chk("rstmiss_busy_cycles", bcnt, 32'd256);
    chk("rstmiss_no_response", {31'd0, stray}, 32'd0);
    chk("rstmiss_hit_cnt", {16'd0, m0_hit_cnt}, 32'd0);

    // Write policy on a cached line
    do_read(21'h01234, 16'hBEEF, 1'b0);
    do_write(21'h01234, 2'b01, 16'h0055);
    chk("wr_latency", w_lat, 32'd3);
    chk("wr_we_m0", {31'd0, w_we0}, 32'd1);
    chk("wr_we_m1", {31'd0, w_we1}, 32'd1);
    chk("wr_addr", {11'd0, w_addr}, 32'h00001234);
    chk("wr_be", {30'd0, w_be}, 32'd1);
    chk("wr_wdata", {16'd0, w_wdata}, 32'h00000055);
    chk("wr_done_m1", {31'd0, w_done1}, 32'd1);
    do_read(21'h01234, 16'h3333, 1'b0);
    chk("wm0_miss", {31'd0, r_saw}, 32'd1);
    chk("wm0_rdata", {16'd0, r_data}, 32'h00003333);
    chk("wm0_miss_cnt", {16'd0, m0_miss_cnt}, 32'd2);
    chk("wm1_latency", r1_lat, 32'd2);
    chk("wm1_rdata", {16'd0, r1_data}, 32'h0000BE55);
    chk("wm1_hit_flag", {31'd0, m1_hit}, 32'd1);
    chk("wm1_hit_cnt", {16'd0, m1_hit_cnt}, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
